// File: rtl/asyn_fifo_rd_stream.sv
// Read-side adapter for the async FIFO: prefetches words into a skid
// buffer and presents them as a valid/ready stream with flush and status.
module asyn_fifo_rd_stream #(
   parameter int DATA_WIDTH = 18,
   parameter int SKID_DEPTH = 2,
   parameter int RD_LATENCY = 1
) (
   input  logic                          clk_rd_i,
   input  logic                          rrst_n_i,
   input  logic                          en_i,
   input  logic                          flush_i,
   input  logic                          fifo_empty_i,
   input  logic [DATA_WIDTH-1:0]         fifo_data_i,
   output logic                          fifo_rd_o,
   output logic                          fifo_oe_o,
   output logic                          m_valid_o,
   output logic [DATA_WIDTH-1:0]         m_data_o,
   input  logic                          m_ready_i,
   output logic [$clog2(SKID_DEPTH+1)-1:0] level_o,
   output logic                          busy_o,
   output logic [31:0]                   word_cnt_o
);

   localparam int LW = $clog2(SKID_DEPTH + 1);
   localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

   if (SKID_DEPTH < RD_LATENCY + 1) begin : g_depth_chk
      $error("SKID_DEPTH must be >= RD_LATENCY+1");
   end
   if (RD_LATENCY < 1) begin : g_lat_chk
      $error("RD_LATENCY must be >= 1");
   end

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic                  r_oe;
   logic [RD_LATENCY-1:0] r_tag_v;
   logic [RD_LATENCY-1:0] r_tag_d;
   logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [LW-1:0]         r_level;
   logic [31:0]           r_cnt;

   logic [31:0]           w_inflight;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_rd;
   logic                  w_room;
   logic [PW-1:0]         w_head_nx;
   logic [PW-1:0]         w_tail_nx;

   assign w_head_nx = (r_head == PW'(SKID_DEPTH - 1)) ? '0 : r_head + 1'b1;
   assign w_tail_nx = (r_tail == PW'(SKID_DEPTH - 1)) ? '0 : r_tail + 1'b1;

   // Reads are only issued when the word is guaranteed a skid slot on return
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         w_inflight = w_inflight + 32'(r_tag_v[i]);
      end
      w_pop      = (r_level != '0) & m_ready_i;
      w_room     = (32'(r_level) + w_inflight - 32'(w_pop)) < 32'(SKID_DEPTH);
      w_rd       = 1'b0;
      w_push     = 1'b0;
      w_state_nx = r_state;
      unique case (r_state)
         ST_RUN: begin
            w_rd   = r_oe & en_i & ~flush_i & ~fifo_empty_i & w_room;
            w_push = r_tag_v[RD_LATENCY-1] & ~r_tag_d[RD_LATENCY-1] & ~flush_i;
            if (flush_i) w_state_nx = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (w_inflight == '0 && !flush_i) w_state_nx = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_rd_i or negedge rrst_n_i) begin
      if (!rrst_n_i) begin
         r_state <= ST_RUN;
         r_oe    <= 1'b0;
         r_tag_v <= '0;
         r_tag_d <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_level <= '0;
         r_cnt   <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_oe       <= 1'b1;
         r_state    <= w_state_nx;
         r_tag_v[0] <= w_rd;
         r_tag_d[0] <= 1'b0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_d[i] <= r_tag_d[i-1] | flush_i;
         end
         if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_tail] <= fifo_data_i;
               r_tail        <= w_tail_nx;
            end
            if (w_pop) r_head <= w_head_nx;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
         end
         if (w_pop) r_cnt <= r_cnt + 32'd1;
      end
   end

   assign fifo_rd_o  = w_rd;
   assign fifo_oe_o  = r_oe;
   assign m_valid_o  = (r_level != '0);
   assign m_data_o   = r_mem[r_head];
   assign level_o    = r_level;
   assign busy_o     = (w_inflight != '0) | (r_state == ST_FLUSH);
   assign word_cnt_o = r_cnt;

endmodule

// File: tb/tb_asyn_fifo_rd_stream.sv
// Scoreboard bench for asyn_fifo_rd_stream with a behavioural FIFO model
// (RD_LATENCY=1) and directed scenarios.
module tb_asyn_fifo_rd_stream;

   localparam int DW = 18;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en = 1'b0;
   logic          flush = 1'b0;
   logic          empty = 1'b1;
   logic          ready = 1'b0;
   logic [DW-1:0] fdata = '0;
   logic          fifo_rd;
   logic          oe;
   logic          mv;
   logic [DW-1:0] mdata;
   logic [1:0]    level;
   logic          busy;
   logic [31:0]   wcnt;

   int total = 0;
   int bad = 0;
   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] pend;
   bit   pend_v = 1'b0;
   int   cyc = 0;
   int   first_rd = -1;
   int   first_v = -1;
   int   last_hs = -1;
   int   max_lvl = 0;
   int   v_cycles = 0;
   int   rd_pulses = 0;

   always #5 clk = ~clk;

   asyn_fifo_rd_stream #(
      .DATA_WIDTH(DW),
      .SKID_DEPTH(2),
      .RD_LATENCY(1)
   ) dut (
      .clk_rd_i    (clk),
      .rrst_n_i    (rst_n),
      .en_i        (en),
      .flush_i     (flush),
      .fifo_empty_i(empty),
      .fifo_data_i (fdata),
      .fifo_rd_o   (fifo_rd),
      .fifo_oe_o   (oe),
      .m_valid_o   (mv),
      .m_data_o    (mdata),
      .m_ready_i   (ready),
      .level_o     (level),
      .busy_o      (busy),
      .word_cnt_o  (wcnt)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // FIFO model: read sampled mid-cycle, data/empty update just after the edge
   always @(negedge clk) begin
      if (rst_n && fifo_rd) begin
         rd_pulses++;
         if (first_rd < 0) first_rd = cyc;
         total++;
         if (fq.size() == 0) begin
            bad++;
            $display("FAIL rd_on_empty: got read want no read");
         end else begin
            pend   = fq.pop_front();
            pend_v = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (pend_v) begin
         fdata  = pend;
         pend_v = 1'b0;
      end
      empty = (fq.size() == 0);
   end

   // Stream monitor / scoreboard
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (rst_n && mv) begin
         v_cycles++;
         if (first_v < 0) first_v = cyc;
         if (int'(level) > max_lvl) max_lvl = int'(level);
         if (ready) begin
            last_hs = cyc;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL stream_extra: got %0h want none", mdata);
            end else begin
               e = exp_q.pop_front();
               if (mdata !== e) begin
                  bad++;
                  $display("FAIL stream_data: got %0h want %0h", mdata, e);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cnt(input logic [31:0] target, input string name);
      for (int i = 0; i < 300; i++) begin
         if (wcnt == target) break;
         step();
      end
      chk(name, wcnt, target);
   endtask

   task automatic load(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         fq.push_back(base + DW'(i));
         exp_q.push_back(base + DW'(i));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd"}, 32'(fifo_rd), 0);
      chk({tag, "_oe"}, 32'(oe), 0);
      chk({tag, "_valid"}, 32'(mv), 0);
      chk({tag, "_data"}, 32'(mdata), 0);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_cnt"}, wcnt, 0);
   endtask

   initial begin
      #3 rst_n = 1'b0;
      step();
      step();
      chk_zero("rst0");
      rst_n = 1'b1;
      chk("oe_before_edge", 32'(oe), 0);
      step();
      chk("oe_after_edge", 32'(oe), 1);

      // empty FIFO: never read
      en = 1'b1;
      ready = 1'b1;
      rd_pulses = 0;
      repeat (5) step();
      chk("empty_no_rd", rd_pulses, 0);

      // streaming at full rate
      first_rd = -1;
      first_v = -1;
      max_lvl = 0;
      load(18'h01, 8);
      wait_cnt(8, "t2_cnt");
      step();
      step();
      chk("t2_latency", 32'(first_v - first_rd), 2);
      chk("t2_b2b", 32'(last_hs - first_v), 7);
      chk("t2_maxlvl", 32'(max_lvl <= 2), 1);
      chk("t2_drain", 32'(exp_q.size()), 0);

      // backpressure
      ready = 1'b0;
      rd_pulses = 0;
      load(18'h01, 8);
      repeat (10) step();
      chk("t3_rd_pulses", rd_pulses, 2);
      chk("t3_level", 32'(level), 2);
      chk("t3_valid", 32'(mv), 1);
      chk("t3_head", 32'(mdata), 32'h01);
      ready = 1'b1;
      wait_cnt(16, "t3_cnt");
      step();
      chk("t3_rd_total", rd_pulses, 8);
      chk("t3_drain", 32'(exp_q.size()), 0);

      // single word
      rd_pulses = 0;
      v_cycles = 0;
      load(18'h2A, 1);
      repeat (6) step();
      chk("t4_rd", rd_pulses, 1);
      chk("t4_vcyc", v_cycles, 1);
      chk("t4_cnt", wcnt, 17);

      // flush with one held word and one landing
      ready = 1'b0;
      fq.push_back(18'h31);
      fq.push_back(18'h32);
      fq.push_back(18'h33);
      fq.push_back(18'h34);
      exp_q.push_back(18'h33);
      exp_q.push_back(18'h34);
      for (int i = 0; i < 20; i++) begin
         if (level == 2'd1) break;
         step();
      end
      chk("t5_pre_level", 32'(level), 1);
      chk("t5_pre_busy", 32'(busy), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t5_valid", 32'(mv), 0);
      chk("t5_level", 32'(level), 0);
      chk("t5_busy", 32'(busy), 1);
      chk("t5_no_rd", 32'(fifo_rd), 0);
      step();
      chk("t5_busy_done", 32'(busy), 0);
      chk("t5_resume_rd", 32'(fifo_rd), 1);
      chk("t5_cnt", wcnt, 17);
      ready = 1'b1;
      wait_cnt(19, "t5_cnt_after");
      step();
      chk("t5_drain", 32'(exp_q.size()), 0);

      // prefetch disable mid-stream
      load(18'h41, 8);
      wait_cnt(22, "t6_cnt_pre");
      en = 1'b0;
      rd_pulses = 0;
      repeat (5) step();
      chk("t6_cnt_stop", wcnt, 24);
      chk("t6_no_rd", rd_pulses, 0);
      chk("t6_valid", 32'(mv), 0);
      en = 1'b1;
      wait_cnt(27, "t6_cnt_end");
      step();
      chk("t6_drain", 32'(exp_q.size()), 0);

      // reset mid-stream
      load(18'h51, 8);
      wait_cnt(29, "t1_cnt_pre");
      rst_n = 1'b0;
      fq.delete();
      exp_q.delete();
      pend_v = 1'b0;
      #1;
      chk_zero("rst1");
      step();
      step();
      rst_n = 1'b1;
      chk("t1_oe_before", 32'(oe), 0);
      step();
      chk("t1_oe_after", 32'(oe), 1);
      rd_pulses = 0;
      repeat (5) step();
      chk("t1_empty_no_rd", rd_pulses, 0);
      chk("t1_cnt", wcnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
